// File: rtl/json_tx_pkg.sv
// Shared constants, FSM encoding and frame-size helpers for the JSON telemetry transmitter.
package json_tx_pkg;

  localparam logic [7:0] ASC_LBRACE = 8'h7B;
  localparam logic [7:0] ASC_RBRACE = 8'h7D;
  localparam logic [7:0] ASC_QUOTE  = 8'h22;
  localparam logic [7:0] ASC_COLON  = 8'h3A;
  localparam logic [7:0] ASC_COMMA  = 8'h2C;
  localparam logic [7:0] ASC_ZERO   = 8'h30;
  localparam logic [7:0] ASC_NL     = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_KEY,
    S_DIGITS,
    S_SEP,
    S_NL,
    S_FIN
  } state_t;

  // Bytes in one frame: '{' + per channel ("k": + digits + separator) + '\n'.
  function automatic int frame_len(input int n_ch, input int dig);
    return n_ch * (5 + dig) + 2;
  endfunction

  function automatic int pow10(input int dig);
    int r;
    r = 1;
    for (int i = 0; i < dig; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/json_frame_tx_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter; one input bit per cycle.
// done pulses on the cycle bcd holds the final result; bcd then holds until the next start.
module bin2bcd
  import json_tx_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int DIG    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   bin,
  output logic [4*DIG-1:0]    bcd,
  output logic                done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic [4*DIG-1:0]  adj;

  // Add 3 to every digit that is 5 or more before the next shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Load on start, then shift one binary bit into the BCD register per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg <= bin;
        bcd   <= '0;
        cnt   <= CNT_W'(DATA_W);
      end else if (cnt != '0) begin
        bcd   <= {adj[4*DIG-2:0], shreg[DATA_W-1]};
        shreg <= shreg << 1;
        cnt   <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/json_frame_tx.sv
// Formats a snapshot of N_CH channel values as a one-line JSON object and
// streams it byte by byte to a UART transmitter.
// Byte handshake: a byte moves when byte_valid && byte_ready at a rising edge;
// while byte_valid is high and byte_ready low, byte_data holds, and byte_valid
// only falls after a transfer (or on reset).
module json_frame_tx
  import json_tx_pkg::*;
#(
  parameter int                  N_CH       = 3,
  parameter int                  DATA_W     = 10,
  parameter int                  DIG        = 3,
  parameter logic [8*N_CH-1:0]   KEYS       = "RLT",
  parameter int                  PERIOD_CYC = 5_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     auto_en,
  input  logic [N_CH*DATA_W-1:0]   values,
  output logic [7:0]               byte_data,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     sat,
  output logic [15:0]              frame_cnt
);

  localparam int          CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [31:0] MAX_VAL = 32'(pow10(DIG) - 1);

  state_t            state;
  logic              pending;
  logic [31:0]       pcnt;
  logic              tick;
  logic              trig;
  logic              xfer;
  logic              last_ch;
  logic [DATA_W-1:0] snap    [N_CH];
  logic [DATA_W-1:0] clamped [N_CH];
  logic [N_CH-1:0]   over;
  logic              sat_frame;
  logic [CH_W-1:0]   ch;
  logic [1:0]        kidx;
  logic [2:0]        didx;
  logic              conv_start;
  logic              conv_done;
  logic              conv_ready;
  logic [4*DIG-1:0]  bcd;

  assign tick    = auto_en && (pcnt == 32'(PERIOD_CYC - 1));
  assign trig    = start || tick;
  assign xfer    = byte_valid && byte_ready;
  assign last_ch = (ch == CH_W'(N_CH - 1));

  function automatic logic [7:0] digit_char(input logic [4*DIG-1:0] b, input logic [2:0] i);
    return ASC_ZERO + {4'h0, b[4*i +: 4]};
  endfunction

  // Saturate each channel to the largest value DIG digits can show.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      over[k]    = 32'(values[DATA_W*k +: DATA_W]) > MAX_VAL;
      clamped[k] = over[k] ? MAX_VAL[DATA_W-1:0] : values[DATA_W*k +: DATA_W];
    end
  end

  // Auto-mode period counter; held at zero while auto mode is off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt <= '0;
    else if (!auto_en || tick) pcnt <= '0;
    else pcnt <= pcnt + 32'd1;
  end

  bin2bcd #(.DATA_W(DATA_W), .DIG(DIG)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (snap[ch]),
    .bcd   (bcd),
    .done  (conv_done)
  );

  // Frame sequencer: walks the frame layout and drives the registered byte stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sat        <= 1'b0;
      pending    <= 1'b0;
      frame_cnt  <= 16'd0;
      sat_frame  <= 1'b0;
      ch         <= '0;
      kidx       <= '0;
      didx       <= '0;
      conv_start <= 1'b0;
      conv_ready <= 1'b0;
      for (int k = 0; k < N_CH; k++) snap[k] <= '0;
    end else begin
      conv_start <= 1'b0;
      done       <= 1'b0;
      sat        <= 1'b0;
      if (conv_done) conv_ready <= 1'b1;
      // Only one frame can be queued behind the current one.
      if (state != S_IDLE && trig) pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (trig || pending) begin
            for (int k = 0; k < N_CH; k++) snap[k] <= clamped[k];
            sat_frame  <= |over;
            pending    <= 1'b0;
            busy       <= 1'b1;
            ch         <= '0;
            byte_data  <= ASC_LBRACE;
            byte_valid <= 1'b1;
            state      <= S_OPEN;
          end
        end
        S_OPEN: begin
          if (xfer) begin
            state      <= S_KEY;
            kidx       <= 2'd0;
            byte_data  <= ASC_QUOTE;
            conv_start <= 1'b1;
            conv_ready <= 1'b0;
          end
        end
        S_KEY: begin
          if (xfer) begin
            kidx <= kidx + 2'd1;
            case (kidx)
              2'd0: byte_data <= KEYS[8*ch +: 8];
              2'd1: byte_data <= ASC_QUOTE;
              2'd2: byte_data <= ASC_COLON;
              default: begin
                // First digit goes out immediately only if the conversion already finished.
                state      <= S_DIGITS;
                didx       <= 3'(DIG - 1);
                byte_data  <= digit_char(bcd, 3'(DIG - 1));
                byte_valid <= conv_ready;
              end
            endcase
          end
        end
        S_DIGITS: begin
          if (!byte_valid) begin
            if (conv_ready) begin
              byte_valid <= 1'b1;
              byte_data  <= digit_char(bcd, didx);
            end
          end else if (xfer) begin
            if (didx == 3'd0) begin
              state     <= S_SEP;
              byte_data <= last_ch ? ASC_RBRACE : ASC_COMMA;
            end else begin
              didx      <= didx - 3'd1;
              byte_data <= digit_char(bcd, didx - 3'd1);
            end
          end
        end
        S_SEP: begin
          if (xfer) begin
            if (last_ch) begin
              state     <= S_NL;
              byte_data <= ASC_NL;
            end else begin
              ch         <= ch + 1'b1;
              state      <= S_KEY;
              kidx       <= 2'd0;
              byte_data  <= ASC_QUOTE;
              conv_start <= 1'b1;
              conv_ready <= 1'b0;
            end
          end
        end
        S_NL: begin
          if (xfer) begin
            byte_valid <= 1'b0;
            state      <= S_FIN;
            done       <= 1'b1;
            sat        <= sat_frame;
            busy       <= 1'b0;
            frame_cnt  <= frame_cnt + 16'd1;
          end
        end
        S_FIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_json_frame_tx.sv
// Directed scenarios with randomised values and back-pressure for json_frame_tx.
module tb_json_frame_tx;

  localparam int N_CH   = 3;
  localparam int DATA_W = 10;
  localparam int DIG    = 3;
  localparam int PERIOD = 2000;
  localparam int VW     = N_CH * DATA_W;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           auto_en;
  logic [VW-1:0]  values;
  logic [7:0]     byte_data;
  logic           byte_valid;
  logic           byte_ready;
  logic           busy;
  logic           done;
  logic           sat;
  logic [15:0]    frame_cnt;

  json_frame_tx #(
    .N_CH(N_CH), .DATA_W(DATA_W), .DIG(DIG), .KEYS("RLT"), .PERIOD_CYC(PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .values(values),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .done(done), .sat(sat), .frame_cnt(frame_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          start_q[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          ready_pct = 100;
  int          exp_frames = 0;
  logic        last_sat = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_busy = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  string       keys_str = "RLT";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // ---------------- reference model ----------------
  task automatic add_frame(input logic [VW-1:0] v);
    int maxv;
    maxv = 10**DIG - 1;
    exp_q.push_back("{");
    for (int k = 0; k < N_CH; k++) begin
      int val;
      val = int'(v[k*DATA_W +: DATA_W]);
      if (val > maxv) val = maxv;
      exp_q.push_back("\"");
      exp_q.push_back(keys_str[N_CH-1-k]);
      exp_q.push_back("\"");
      exp_q.push_back(":");
      for (int p = DIG - 1; p >= 0; p--) exp_q.push_back(8'(48 + (val / 10**p) % 10));
      exp_q.push_back((k == N_CH - 1) ? 8'h7D : 8'h2C);
    end
    exp_q.push_back(8'h0A);
    exp_frames++;
  endtask

  function automatic logic frame_sat(input logic [VW-1:0] v);
    for (int k = 0; k < N_CH; k++)
      if (int'(v[k*DATA_W +: DATA_W]) > 10**DIG - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [VW-1:0] rand_vals();
    logic [VW-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 1023));
    return v;
  endfunction

  task automatic compare_frames(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver / monitor step ----------------
  // One clock cycle: sample outputs at the falling edge, check stall stability,
  // then drive start and a randomised byte_ready for the next rising edge.
  task automatic step(input logic s);
    @(negedge clk);
    cyc++;
    if (prev_stall) begin
      chk("stall_valid", byte_valid, 1);
      chk("stall_data", byte_data, prev_data);
    end
    if (busy && !prev_busy) start_q.push_back(cyc);
    prev_busy = busy;
    if (done) begin
      done_cnt++;
      last_sat = sat;
    end
    start      = s;
    byte_ready = ($urandom_range(0, 99) < ready_pct);
    if (byte_valid && byte_ready) got_q.push_back(byte_data);
    prev_stall = byte_valid && !byte_ready;
    prev_data  = byte_data;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      step(1'b0);
      n++;
    end
    chk({tag, "_done_reached"}, done_cnt >= target, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int n;
    string lit;
    logic [VW-1:0] va;
    logic [VW-1:0] vb;

    rst = 1'b1; start = 1'b0; auto_en = 1'b0; byte_ready = 1'b0; values = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", byte_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat, 0);
    chk("rst_data", byte_data, 8'h00);
    chk("rst_cnt", frame_cnt, 0);
    rst = 1'b0;

    // Basic frame with full-rate ready
    values    = {10'd999, 10'd0, 10'd500};
    ready_pct = 100;
    step(1'b1);
    step(1'b0);
    chk("lat_valid", byte_valid, 1);
    chk("lat_data", byte_data, 8'h7B);
    chk("lat_busy", busy, 1);
    wait_done("s1", 1, 400);
    chk("s1_busy_low", busy, 0);
    chk("s1_sat", last_sat, 0);
    chk("s1_cnt", frame_cnt, 1);
    step(1'b0);
    chk("s1_done_pulse", done, 0);
    repeat (20) step(1'b0);
    chk("s1_single_done", done_cnt, 1);
    lit = "{\"T\":500,\"L\":000,\"R\":999}\n";
    chk("s1_len", got_q.size(), 26);
    for (int i = 0; i < 26; i++)
      chk($sformatf("s1_lit%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, lit[i]);
    got_q.delete();
    exp_frames = 1;

    // Same values under heavy back-pressure
    ready_pct = 30;
    step(1'b1);
    wait_done("s2", 2, 2000);
    repeat (10) step(1'b0);
    add_frame(values);
    compare_frames("s2");
    chk("s2_sat", last_sat, 0);
    chk("s2_cnt", frame_cnt, exp_frames);

    // Saturating channel 0
    values = rand_vals();
    values[DATA_W-1:0] = 10'd1023;
    ready_pct = 60;
    base = done_cnt;
    step(1'b1);
    wait_done("s3", base + 1, 2000);
    repeat (10) step(1'b0);
    add_frame(values);
    compare_frames("s3");
    chk("s3_sat", last_sat, 1);
    chk("s3_cnt", frame_cnt, exp_frames);

    // Random values and random back-pressure
    for (int r = 0; r < 3; r++) begin
      values    = rand_vals();
      ready_pct = $urandom_range(20, 100);
      base = done_cnt;
      step(1'b1);
      wait_done("s4", base + 1, 2000);
      repeat (10) step(1'b0);
      add_frame(values);
      compare_frames($sformatf("s4_%0d", r));
      chk($sformatf("s4_%0d_sat", r), last_sat, frame_sat(values));
      chk($sformatf("s4_%0d_cnt", r), frame_cnt, exp_frames);
    end

    // Triggers while busy: one pending frame, fresh snapshot
    ready_pct = 100;
    va = rand_vals();
    vb = rand_vals();
    values = va;
    base = done_cnt;
    step(1'b1);
    repeat (5) step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    values = vb;
    chk("s5_first_in_flight", done_cnt, base);
    wait_done("s5", base + 2, 1000);
    repeat (200) step(1'b0);
    chk("s5_two_frames", done_cnt, base + 2);
    add_frame(va);
    add_frame(vb);
    compare_frames("s5");
    chk("s5_cnt", frame_cnt, exp_frames);

    // Reset in the middle of a frame
    values = rand_vals();
    step(1'b1);
    n = 0;
    while (got_q.size() < 10 && n < 200) begin
      step(1'b0);
      n++;
    end
    chk("s6_reached10", got_q.size(), 10);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("s6_rst_valid", byte_valid, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_done", done, 0);
    chk("s6_rst_cnt", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_stall = 1'b0;
    prev_busy  = 1'b0;
    got_q.delete();
    exp_frames = 0;
    base = done_cnt;
    step(1'b1);
    wait_done("s6", base + 1, 400);
    repeat (10) step(1'b0);
    add_frame(values);
    compare_frames("s6");
    chk("s6_cnt", frame_cnt, 1);

    // Periodic triggers
    values = rand_vals();
    ready_pct = 100;
    start_q.delete();
    base = done_cnt;
    auto_en = 1'b1;
    wait_done("s7", base + 3, 7000);
    chk("s7_starts", start_q.size(), 3);
    if (start_q.size() >= 3) begin
      chk("s7_period1", start_q[1] - start_q[0], PERIOD);
      chk("s7_period2", start_q[2] - start_q[1], PERIOD);
    end
    n = 0;
    while (!busy && n < 2100) begin
      step(1'b0);
      n++;
    end
    chk("s7_fourth_started", busy, 1);
    auto_en = 1'b0;
    wait_done("s7_inflight", base + 4, 300);
    repeat (2100) step(1'b0);
    chk("s7_stopped_starts", start_q.size(), 4);
    chk("s7_stopped_done", done_cnt, base + 4);
    repeat (4) add_frame(values);
    compare_frames("s7");
    chk("s7_cnt", frame_cnt, exp_frames);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/json_frame_tx.md
JSON_FRAME_TX -- requirements
Module: json_frame_tx

Interface
REQ-001 Parameter N_CH, default 3: number of telemetry channels, legal range 1..8.
REQ-002 Parameter DATA_W, default 10: unsigned width of each channel value.
REQ-003 Parameter DIG, default 3: decimal digits emitted per value, legal range 1..5.
REQ-004 Parameter KEYS, default "RLT": N_CH ASCII key characters, packed; bits [8k+7:8k] are the key for channel k.
REQ-005 Parameter PERIOD_CYC, default 5_000_000: auto-mode trigger period in clk cycles.
REQ-006 clk  input  1  system clock; all state changes on the rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 start  input  1  one-cycle request to send one frame.
REQ-009 auto_en  input  1  enables periodic frame triggers.
REQ-010 values  input  N_CH*DATA_W  channel k occupies bits [DATA_W*k +: DATA_W].
REQ-011 byte_data  output  8  ASCII byte offered to the UART transmitter.
REQ-012 byte_valid  output  1  byte_data is valid.
REQ-013 byte_ready  input  1  UART accepts the byte; a transfer occurs when byte_valid and byte_ready are both high.
REQ-014 busy  output  1  high from trigger acceptance until the cycle the frame completes.
REQ-015 done  output  1  one-cycle pulse, in the cycle after the '\n' transfer.
REQ-016 sat  output  1  valid with done; high if any channel in the frame was clamped.
REQ-017 frame_cnt  output  16  count of completed frames; wraps from 0xFFFF to 0.

Function
REQ-018 Frame format: '{', then for k = 0..N_CH-1: '"' KEY[k] '"' ':' followed by DIG zero-padded decimal digits, most significant digit first, followed by ',' (or '}' after the last channel), then 0x0A.
REQ-019 Frame length is N_CH*(5+DIG)+2 bytes; with the defaults this is 26 bytes.
REQ-020 Trigger sources: start, and a tick every PERIOD_CYC cycles while auto_en is high.
REQ-021 The period counter clears while auto_en is low.
REQ-022 A trigger while idle is accepted in that cycle: all values are snapshotted and busy rises on the next edge.
REQ-023 A trigger while busy sets a single pending flag; further triggers while the flag is set are dropped.
REQ-024 The pending frame starts in the cycle after done and takes a fresh snapshot at that point.
REQ-025 Clamp: a snapshot value above 10^DIG-1 is replaced by 10^DIG-1 and sets the frame's sat flag.
REQ-026 FSM states: IDLE -> OPEN -> KEY (4 bytes) -> DIGITS -> SEP -> (KEY for next channel, or NL) -> FIN -> IDLE.
REQ-027 FSM state FIN pulses done, increments frame_cnt and clears busy.
REQ-028 Entry to KEY for channel k launches conversion of channel k; DIGITS holds byte_valid low until that conversion completes.
REQ-029 Handshake: byte_data is stable while byte_valid is high and byte_ready is low; byte_valid never drops without a transfer except on reset.
REQ-030 After a transfer, the next byte may be valid on the following edge; byte_valid may stay high across back-to-back bytes.
REQ-031 First-byte latency: '{' is valid on the edge after trigger acceptance.
REQ-032 With byte_ready held high, the only gaps in the byte stream are conversion stalls.

Reset
REQ-033 On rst, the following are driven low immediately: byte_valid, busy, done, sat and pending.
REQ-034 On rst, byte_data goes to 0x00, frame_cnt to 0, the period counter to 0, and the FSM to IDLE.
REQ-035 A reset mid-frame abandons the frame; no partial-frame resume occurs, and the next trigger emits from '{'.

Structure
REQ-036 Package json_tx_pkg holds the ASCII constants ('{' '}' '"' ':' ',' '0' 0x0A), the FSM state enum, and a frame-length function of (N_CH, DIG).
REQ-037 Sub-module bin2bcd is sequential shift-add-3 with a start/done handshake, DATA_W cycles per conversion, and DIG BCD digits output.

Verification
REQ-038 Scenario: defaults, values {999,0,500} for ch2..ch0, byte_ready=1, start pulse -> exactly 26 bytes `{"T":500,"L":000,"R":999}\n`, one done pulse, sat=0, frame_cnt=1.
REQ-039 Scenario: same stimulus with byte_ready randomised at 30% high -> identical byte stream, byte_data stable on every stalled cycle, no dropped or duplicated bytes.
REQ-040 Scenario: ch0=1023 -> "999" emitted for ch0 and sat=1 with done.
REQ-041 Scenario: start, then two more starts while busy -> exactly 2 frames, frame_cnt=2, and the second frame reflects values changed before the first frame's done.
REQ-042 Scenario: auto_en=1, PERIOD_CYC=2000, byte_ready=1 -> a frame begins every 2000 cycles; auto_en=0 stops new frames and a frame in flight completes.
REQ-043 Scenario: rst asserted after the 10th transfer -> byte_valid and busy low immediately; the next start emits a complete 26-byte frame beginning with '{' and frame_cnt=1.
